// File: rtl/jogo_desafio_memoria.sv
// Memory-sequence game: the player repeats a stored button sequence and appends one entry per round.
// Optional inactivity timeout is compiled in with `define TIMEOUT_EN.
module jogo_desafio_memoria (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic [3:0]  botoes,
    output logic        ganhou,
    output logic        perdeu,
    output logic        pronto,
    output logic [3:0]  leds,
    output logic [6:0]  db_contagem,
    output logic [6:0]  db_memoria,
    output logic [6:0]  db_estado,
    output logic [6:0]  db_jogadafeita,
    output logic [6:0]  db_rodada,
    output logic        db_clock,
    output logic        db_tem_jogada,
    output logic        db_timeout,
    output logic        db_jogada_correta,
    output logic        db_enderecoIgualRodada,
    output logic        db_grava,
    output logic [12:0] db_Q
);
    localparam logic [3:0] INICIAL        = 4'h0;
    localparam logic [3:0] PREPARACAO     = 4'h1;
    localparam logic [3:0] MOSTRA         = 4'h2;
    localparam logic [3:0] INICIO_RODADA  = 4'h3;
    localparam logic [3:0] ESPERA         = 4'h4;
    localparam logic [3:0] REGISTRA       = 4'h5;
    localparam logic [3:0] COMPARA        = 4'h6;
    localparam logic [3:0] PROXIMO        = 4'h7;
    localparam logic [3:0] ESPERA_NOVA    = 4'h8;
    localparam logic [3:0] REGISTRA_NOVA  = 4'h9;
    localparam logic [3:0] GRAVA          = 4'hA;
    localparam logic [3:0] PROXIMA_RODADA = 4'hB;
    localparam logic [3:0] FIM_GANHOU     = 4'hC;
    localparam logic [3:0] FIM_PERDEU     = 4'hD;
    localparam logic [3:0] FIM_TIMEOUT    = 4'hE;

    localparam logic [12:0] TIMEOUT_LAST = 13'd4999;
    localparam logic [10:0] MOSTRA_LAST  = 11'd1999;

    logic [3:0]  estado_q, estado_d;
    logic [3:0]  contagem_q, contagem_d;
    logic [3:0]  rodada_q, rodada_d;
    logic [3:0]  jogada_q;
    logic        botao_q;
    logic [12:0] timeout_q, timeout_d;
    logic [10:0] mostra_q, mostra_d;
    logic        acertou_q, acertou_d;
    logic [3:0]  ram [16];

    logic        tem_jogada;
    logic        jogada_correta;
    logic        timeout;
    logic        ram_we;
    logic [3:0]  ram_addr;
    logic [3:0]  ram_data;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tem_jogada     = (|botoes) & ~botao_q;
    assign jogada_correta = (jogada_q == ram[contagem_q]);

    // Gating with reset keeps a write from landing on the edge where reset is already low.
    assign ram_we   = ((estado_q == PREPARACAO) || (estado_q == GRAVA)) && reset;
    assign ram_addr = (estado_q == PREPARACAO) ? 4'h0 : rodada_q + 4'h1;
    assign ram_data = (estado_q == PREPARACAO) ? 4'b0001 : jogada_q;

`ifdef TIMEOUT_EN
    assign timeout    = ((estado_q == ESPERA) || (estado_q == ESPERA_NOVA)) && (timeout_q == TIMEOUT_LAST);
    assign db_timeout = (estado_q == FIM_TIMEOUT);
`else
    assign timeout    = 1'b0;
    assign db_timeout = 1'b0;
`endif

    always_comb begin
        timeout_d = '0;
`ifdef TIMEOUT_EN
        if (((estado_q == ESPERA) || (estado_q == ESPERA_NOVA)) && !tem_jogada && !timeout)
            timeout_d = timeout_q + 13'd1;
`endif
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        estado_d   = estado_q;
        contagem_d = contagem_q;
        rodada_d   = rodada_q;
        mostra_d   = '0;
        acertou_d  = acertou_q;
        case (estado_q)
            INICIAL:       if (iniciar) estado_d = PREPARACAO;
            PREPARACAO: begin
                contagem_d = '0;
                rodada_d   = '0;
                estado_d   = MOSTRA;
            end
            MOSTRA: begin
                if (mostra_q == MOSTRA_LAST) estado_d = INICIO_RODADA;
                else                         mostra_d = mostra_q + 11'd1;
            end
            INICIO_RODADA: begin
                contagem_d = '0;
                estado_d   = ESPERA;
            end
            ESPERA: begin
                if (tem_jogada)   estado_d = REGISTRA;
                else if (timeout) estado_d = FIM_TIMEOUT;
            end
            REGISTRA:      estado_d = COMPARA;
            COMPARA: begin
                acertou_d = jogada_correta;
                if (!jogada_correta)             estado_d = FIM_PERDEU;
                else if (contagem_q != rodada_q) estado_d = PROXIMO;
                else if (rodada_q == 4'hF)       estado_d = PROXIMA_RODADA;
                else                             estado_d = ESPERA_NOVA;
            end
            PROXIMO: begin
                contagem_d = contagem_q + 4'h1;
                estado_d   = ESPERA;
            end
            ESPERA_NOVA: begin
                if (tem_jogada)   estado_d = REGISTRA_NOVA;
                else if (timeout) estado_d = FIM_TIMEOUT;
            end
            REGISTRA_NOVA: estado_d = GRAVA;
            GRAVA:         estado_d = PROXIMA_RODADA;
            PROXIMA_RODADA: begin
                if ((rodada_q == 4'hF) && acertou_q) begin
                    estado_d = FIM_GANHOU;
                end else begin
                    rodada_d = rodada_q + 4'h1;
                    estado_d = INICIO_RODADA;
                end
            end
            FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: if (iniciar) estado_d = PREPARACAO;
            default:       estado_d = INICIAL;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= INICIAL;
            contagem_q <= '0;
            rodada_q   <= '0;
            jogada_q   <= '0;
            botao_q    <= 1'b0;
            timeout_q  <= '0;
            mostra_q   <= '0;
            acertou_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            contagem_q <= contagem_d;
            rodada_q   <= rodada_d;
            botao_q    <= |botoes;
            timeout_q  <= timeout_d;
            mostra_q   <= mostra_d;
            acertou_q  <= acertou_d;
            if (tem_jogada) jogada_q <= botoes;
        end
    end

    // NOTE: the sequence RAM has no reset; its contents survive reset and are rewritten before use.
    always_ff @(posedge clock) begin
        if (ram_we) ram[ram_addr] <= ram_data;
    end

    assign pronto = (estado_q == FIM_GANHOU) || (estado_q == FIM_PERDEU) || (estado_q == FIM_TIMEOUT);
    assign ganhou = (estado_q == FIM_GANHOU);
    assign perdeu = (estado_q == FIM_PERDEU) || (estado_q == FIM_TIMEOUT);
    assign leds   = (estado_q == MOSTRA) ? ram[0] : 4'h0;

    assign db_contagem            = hex7(contagem_q);
    assign db_memoria             = hex7((estado_q == INICIAL) ? 4'h0 : ram[contagem_q]);
    assign db_estado              = hex7(estado_q);
    assign db_jogadafeita         = hex7(jogada_q);
    assign db_rodada              = hex7(rodada_q);
    assign db_clock               = clock;
    assign db_tem_jogada          = tem_jogada;
    assign db_jogada_correta      = (estado_q == COMPARA) && jogada_correta;
    assign db_enderecoIgualRodada = (estado_q != INICIAL) && (contagem_q == rodada_q);
    assign db_grava               = (estado_q == GRAVA);
    assign db_Q                   = timeout_q;
endmodule

// File: tb/tb_jogo_desafio_memoria.sv
// Directed/random bench for jogo_desafio_memoria: game rules modelled as a stored sequence array.
// Timeout expectations follow whether TIMEOUT_EN is defined for the build.
module tb_jogo_desafio_memoria;
    logic        clock = 1'b0;
    logic        reset;
    logic        iniciar;
    logic [3:0]  botoes;
    logic        ganhou, perdeu, pronto;
    logic [3:0]  leds;
    logic [6:0]  db_contagem, db_memoria, db_estado, db_jogadafeita, db_rodada;
    logic        db_clock, db_tem_jogada, db_timeout, db_jogada_correta;
    logic        db_enderecoIgualRodada, db_grava;
    logic [12:0] db_Q;

    int vectors     = 0;
    int miscompares = 0;
    logic [3:0] seq [16];

    always #5 clock = ~clock;

    jogo_desafio_memoria dut (
        .clock                  (clock),
        .reset                  (reset),
        .iniciar                (iniciar),
        .botoes                 (botoes),
        .ganhou                 (ganhou),
        .perdeu                 (perdeu),
        .pronto                 (pronto),
        .leds                   (leds),
        .db_contagem            (db_contagem),
        .db_memoria             (db_memoria),
        .db_estado              (db_estado),
        .db_jogadafeita         (db_jogadafeita),
        .db_rodada              (db_rodada),
        .db_clock               (db_clock),
        .db_tem_jogada          (db_tem_jogada),
        .db_timeout             (db_timeout),
        .db_jogada_correta      (db_jogada_correta),
        .db_enderecoIgualRodada (db_enderecoIgualRodada),
        .db_grava               (db_grava),
        .db_Q                   (db_Q)
    );

    // Active-low gfedcba pattern, built from the lit segments of each hex glyph.
    function automatic logic [6:0] seg(input int v);
        logic [6:0] lit;
        case (v)
            0:  lit = 7'b0111111;
            1:  lit = 7'b0000110;
            2:  lit = 7'b1011011;
            3:  lit = 7'b1001111;
            4:  lit = 7'b1100110;
            5:  lit = 7'b1101101;
            6:  lit = 7'b1111101;
            7:  lit = 7'b0000111;
            8:  lit = 7'b1111111;
            9:  lit = 7'b1101111;
            10: lit = 7'b1110111;
            11: lit = 7'b1111100;
            12: lit = 7'b0111001;
            13: lit = 7'b1011110;
            14: lit = 7'b1111001;
            default: lit = 7'b1110001;
        endcase
        return ~lit;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_state(input int st, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (db_estado === seg(st)) break;
            step(1);
        end
        check(tag, db_estado, seg(st));
    endtask

    task automatic press(input logic [3:0] b);
        botoes = b;
        #1;
        check("tem_jogada_pulse", db_tem_jogada, 1);
        step(1);
        check("tem_jogada_single", db_tem_jogada, 0);
        check("jogadafeita", db_jogadafeita, seg(b));
        botoes = 4'b0000;
    endtask

    task automatic start_game();
        int lit_cycles;
        int stray;
        lit_cycles = 0;
        stray      = 0;
        seq[0]     = 4'b0001;
        iniciar    = 1'b1;
        for (int i = 0; i < 2100; i++) begin
            if (i == 5) iniciar = 1'b0;
            if (db_estado === seg(2) && leds === 4'b0001) lit_cycles++;
            if (db_estado !== seg(2) && leds !== 4'b0000) stray++;
            if (db_estado === seg(4)) break;
            step(1);
        end
        iniciar = 1'b0;
        check("start_espera", db_estado, seg(4));
        check("leds_lit_cycles", lit_cycles, 2000);
        check("leds_dark_elsewhere", stray, 0);
    endtask

    task automatic play_round(input int r, input int bad_pos, input logic [3:0] forced_new);
        logic [3:0] b;
        logic [3:0] nova;
        int writes;
        for (int p = 0; p <= r; p++) begin
            wait_state(4, 20, "espera");
            check("contagem", db_contagem, seg(p));
            check("rodada", db_rodada, seg(r));
            check("memoria", db_memoria, seg(seq[p]));
            check("endereco_igual_rodada", db_enderecoIgualRodada, (p == r));
            if (p == bad_pos) begin
                do b = 4'($urandom_range(1, 15)); while (b == seq[p]);
            end else begin
                b = seq[p];
            end
            press(b);
            step(1);
            check("estado_compara", db_estado, seg(6));
            check("jogada_correta", db_jogada_correta, (b == seq[p]));
            if (p == bad_pos) begin
                wait_state(13, 5, "fim_perdeu");
                check("perdeu", perdeu, 1);
                check("pronto_perdeu", pronto, 1);
                check("ganhou_perdeu", ganhou, 0);
                check("timeout_perdeu", db_timeout, 0);
                return;
            end
        end
        if (r == 15) begin
            wait_state(12, 10, "fim_ganhou");
            return;
        end
        wait_state(8, 10, "espera_nova");
        nova = (forced_new != 4'b0000) ? forced_new : 4'(4'b0001 << $urandom_range(0, 3));
        seq[r + 1] = nova;
        press(nova);
        writes = 0;
        for (int i = 0; i < 10 && db_estado !== seg(11); i++) begin
            if (db_grava === 1'b1) writes++;
            step(1);
        end
        check("grava_pulses", writes, 1);
        check("estado_proxima_rodada", db_estado, seg(11));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        iniciar = 1'b0;
        botoes  = 4'b0000;
        step(2);
        check("rst_estado", db_estado, seg(0));
        check("rst_contagem", db_contagem, seg(0));
        check("rst_rodada", db_rodada, seg(0));
        check("rst_jogadafeita", db_jogadafeita, seg(0));
        check("rst_memoria", db_memoria, seg(0));
        check("rst_flags", {ganhou, perdeu, pronto, db_timeout, db_tem_jogada,
                            db_jogada_correta, db_enderecoIgualRodada, db_grava, db_clock}, 0);
        check("rst_leds", leds, 0);
        check("rst_q", db_Q, 0);
        reset = 1'b1;
        step(3);
        check("idle_hold", db_estado, seg(0));

        // Game 1: two rounds built from 0001,0010,0100, then a wrong entry.
        start_game();
        play_round(0, -1, 4'b0010);
        play_round(1, -1, 4'b0100);
        play_round(2, $urandom_range(0, 2), 4'b0000);
        step(5);
        check("fim_perdeu_hold", db_estado, seg(13));

        // Game 2: one round, then no input at all.
        start_game();
        play_round(0, -1, 4'b0000);
        wait_state(4, 10, "espera_idle");
        step(4999);
`ifdef TIMEOUT_EN
        check("timeout_count", db_Q, 4999);
        check("timeout_not_yet", db_estado, seg(4));
        step(1);
        check("fim_timeout", db_estado, seg(14));
        check("db_timeout", db_timeout, 1);
        check("perdeu_timeout", perdeu, 1);
        check("pronto_timeout", pronto, 1);
        check("ganhou_timeout", ganhou, 0);
        check("timeout_q_cleared", db_Q, 0);
`else
        check("timeout_held", db_Q, 0);
        step(1);
        check("no_timeout_state", db_estado, seg(4));
        check("no_db_timeout", db_timeout, 0);
        check("no_perdeu", perdeu, 0);
`endif

        // Asynchronous reset between clock edges aborts the game.
        #2 reset = 1'b0;
        #1;
        check("async_rst_estado", db_estado, seg(0));
        check("async_rst_rodada", db_rodada, seg(0));
        check("async_rst_q", db_Q, 0);
        check("async_rst_pronto", pronto, 0);
        step(1);
        reset = 1'b1;
        step(1);

        // Game 3: all 16 positions, random appended entries.
        start_game();
        for (int r = 0; r < 16; r++) play_round(r, -1, 4'b0000);
        check("ganhou", ganhou, 1);
        check("pronto_ganhou", pronto, 1);
        check("perdeu_ganhou", perdeu, 0);
        check("rodada_final", db_rodada, seg(15));
        iniciar = 1'b1;
        step(1);
        iniciar = 1'b0;
        check("restart_preparacao", db_estado, seg(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
